// File: rtl/fpga_mem_pkg.sv
// Shared definitions for the RAM-port initiators: the address-width helper,
// the DMA engine state encoding and the transfer mode constants.
package fpga_mem_pkg;

    function automatic int CLOG2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        // A one-byte RAM still needs a 1-bit address bus.
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        LATCH = 3'd2,
        WR    = 3'd3,
        DONE  = 3'd4
    } dma_state_t;

    localparam logic MODE_COPY = 1'b0;
    localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram_dma_engine.sv
// Copy/fill DMA initiator for a single synchronous RAM port. Copy takes three
// cycles per byte (read, latch, write); fill writes one byte per cycle.
module ram_dma_engine
    import fpga_mem_pkg::*;
#(
    parameter  int P_size = 1024,
    localparam int AW     = CLOG2(P_size)
) (
    input  logic          G_clock,
    input  logic          G_reset,
    input  logic          G_start,
    input  logic          G_mode,
    input  logic [AW-1:0] G_src,
    input  logic [AW-1:0] G_dst,
    input  logic [AW-1:0] G_len,
    input  logic [7:0]    G_fill,
    output logic          G_busy,
    output logic          G_done,
    output logic          G_mem_cs,
    output logic          G_mem_rdwr,
    output logic [AW-1:0] G_mem_addr,
    output logic [7:0]    G_mem_wr_data,
    input  logic [7:0]    G_mem_rd_data
);

    dma_state_t    state_reg, state_next;
    logic [AW-1:0] src_ptr_reg, src_ptr_next;
    logic [AW-1:0] dst_ptr_reg, dst_ptr_next;
    logic [AW-1:0] cnt_reg, cnt_next;
    logic          mode_reg, mode_next;
    logic [7:0]    fill_reg, fill_next;
    logic [7:0]    data_reg, data_next;

    logic          busy_reg, busy_next;
    logic          done_reg, done_next;
    logic          cs_reg, cs_next;
    logic          rdwr_reg, rdwr_next;
    logic [AW-1:0] addr_reg, addr_next;
    logic [7:0]    wr_data_reg, wr_data_next;

    // Pointers wrap explicitly so non-power-of-two RAM sizes work too.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(P_size - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge G_clock or posedge G_reset) begin
        if (G_reset) begin
            state_reg   <= IDLE;
            src_ptr_reg <= '0;
            dst_ptr_reg <= '0;
            cnt_reg     <= '0;
            mode_reg    <= MODE_COPY;
            fill_reg    <= '0;
            data_reg    <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            cs_reg      <= 1'b0;
            rdwr_reg    <= 1'b1;
            addr_reg    <= '0;
            wr_data_reg <= '0;
        end else begin
            state_reg   <= state_next;
            src_ptr_reg <= src_ptr_next;
            dst_ptr_reg <= dst_ptr_next;
            cnt_reg     <= cnt_next;
            mode_reg    <= mode_next;
            fill_reg    <= fill_next;
            data_reg    <= data_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
            cs_reg      <= cs_next;
            rdwr_reg    <= rdwr_next;
            addr_reg    <= addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        src_ptr_next = src_ptr_reg;
        dst_ptr_next = dst_ptr_reg;
        cnt_next     = cnt_reg;
        mode_next    = mode_reg;
        fill_next    = fill_reg;
        data_next    = data_reg;

        case (state_reg)
            IDLE: begin
                if (G_start) begin
                    src_ptr_next = G_src;
                    dst_ptr_next = G_dst;
                    cnt_next     = G_len;
                    mode_next    = G_mode;
                    fill_next    = G_fill;
                    if (G_len == '0) begin
                        state_next = DONE;
                    end else if (G_mode == MODE_FILL) begin
                        state_next = WR;
                    end else begin
                        state_next = RD;
                    end
                end
            end
            RD: begin
                state_next = LATCH;
            end
            LATCH: begin
                data_next  = G_mem_rd_data;
                state_next = WR;
            end
            WR: begin
                src_ptr_next = ptr_inc(src_ptr_reg);
                dst_ptr_next = ptr_inc(dst_ptr_reg);
                cnt_next     = cnt_reg - 1'b1;
                if (cnt_reg == AW'(1)) begin
                    state_next = DONE;
                end else if (mode_reg == MODE_FILL) begin
                    state_next = WR;
                end else begin
                    state_next = RD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered port
    // values line up with the state they belong to.
    always_comb begin
        busy_next    = 1'b0;
        done_next    = 1'b0;
        cs_next      = 1'b0;
        rdwr_next    = 1'b1;
        addr_next    = '0;
        wr_data_next = '0;

        case (state_next)
            RD, LATCH: begin
                busy_next = 1'b1;
                cs_next   = 1'b1;
                addr_next = src_ptr_next;
            end
            WR: begin
                busy_next    = 1'b1;
                cs_next      = 1'b1;
                rdwr_next    = 1'b0;
                addr_next    = dst_ptr_next;
                wr_data_next = (mode_next == MODE_FILL) ? fill_next : data_next;
            end
            DONE: begin
                done_next = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign G_busy        = busy_reg;
    assign G_done        = done_reg;
    assign G_mem_cs      = cs_reg;
    assign G_mem_rdwr    = rdwr_reg;
    assign G_mem_addr    = addr_reg;
    assign G_mem_wr_data = wr_data_reg;

endmodule

// File: tb/tb_ram_dma_engine.sv
// Randomized and directed bench for ram_dma_engine driving a behavioural
// single-port view of a RAM, checked against a byte-level reference memory.
module tb_ram_dma_engine;

    localparam int P  = 1024;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          mode;
    logic [AW-1:0] src, dst, len;
    logic [7:0]    fill;
    logic          busy, done, mem_cs, mem_rdwr;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wr_data, mem_rd_data;

    always #5 clk = ~clk;

    ram_dma_engine #(.P_size(P)) dut (
        .G_clock      (clk),
        .G_reset      (rst),
        .G_start      (start),
        .G_mode       (mode),
        .G_src        (src),
        .G_dst        (dst),
        .G_len        (len),
        .G_fill       (fill),
        .G_busy       (busy),
        .G_done       (done),
        .G_mem_cs     (mem_cs),
        .G_mem_rdwr   (mem_rdwr),
        .G_mem_addr   (mem_addr),
        .G_mem_wr_data(mem_wr_data),
        .G_mem_rd_data(mem_rd_data)
    );

    // RAM port 0 model with a backdoor used only while the engine is idle.
    logic [7:0]    ram [0:P-1];
    logic [7:0]    ram_q;
    logic          bd_we = 1'b0;
    logic [AW-1:0] bd_addr;
    logic [7:0]    bd_data;

    always @(posedge clk) begin
        if (bd_we) begin
            ram[bd_addr] <= bd_data;
        end else if (mem_cs) begin
            if (mem_rdwr) ram_q <= ram[mem_addr];
            else          ram[mem_addr] <= mem_wr_data;
        end
    end
    assign mem_rd_data = mem_cs ? ram_q : 8'h00;

    logic [7:0] ref_mem [0:P-1];

    // Activity monitor sampled on the falling edge.
    logic          mon_clr = 1'b1;
    int            busy_cnt, done_cnt, cs_cnt, wr_idx, proto_bad;
    logic [AW-1:0] wr_log [0:2047];

    always @(negedge clk) begin
        if (mon_clr) begin
            busy_cnt  <= 0;
            done_cnt  <= 0;
            cs_cnt    <= 0;
            wr_idx    <= 0;
            proto_bad <= 0;
        end else begin
            busy_cnt <= busy_cnt + int'(busy);
            done_cnt <= done_cnt + int'(done);
            cs_cnt   <= cs_cnt + int'(mem_cs);
            if (mem_cs && !mem_rdwr) begin
                wr_log[wr_idx[10:0]] <= mem_addr;
                wr_idx <= wr_idx + 1;
            end
            if ((busy != mem_cs) ||
                (!mem_cs && (!mem_rdwr || mem_addr != '0 || mem_wr_data != 8'h00)))
                proto_bad <= proto_bad + 1;
        end
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input int a, input logic [7:0] d);
        bd_addr = AW'(a);
        bd_data = d;
        bd_we   = 1'b1;
        @(posedge clk);
        #1 bd_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic mon_clear();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic scramble_inputs();
        mode = 1'($urandom);
        src  = AW'($urandom);
        dst  = AW'($urandom);
        len  = AW'($urandom);
        fill = 8'($urandom);
    endtask

    task automatic check_mem(input string tag);
        int n;
        n = 0;
        for (int a = 0; a < P; a++) if (ram[a] !== ref_mem[a]) n++;
        chk(tag, n, 0);
    endtask

    task automatic check_idle(input string tag);
        @(negedge clk);
        chk(tag, int'({busy, done, mem_cs, mem_rdwr, mem_addr, mem_wr_data}),
            int'({1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 8'd0}));
    endtask

    // extra: 0 = plain, 1 = start pulse mid-transfer, 2 = start during done
    task automatic run_op(input logic m, input int s, input int d, input int l,
                          input logic [7:0] f, input int extra);
        int  exp_busy, lat, budget, order_bad;
        bit  seen;
        for (int i = 0; i < l; i++)
            ref_mem[(d + i) % P] = (m == 1'b1) ? f : ref_mem[(s + i) % P];
        exp_busy = (l == 0) ? 0 : ((m == 1'b1) ? l : 3 * l);
        budget   = 3 * l + 20;

        mon_clear();
        @(posedge clk);
        #1;
        start = 1'b1; mode = m; src = AW'(s); dst = AW'(d); len = AW'(l); fill = f;
        @(posedge clk);
        #1;
        start = 1'b0;
        scramble_inputs();
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat < budget) begin
            @(negedge clk);
            lat++;
            if (extra == 1 && lat == 7) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                if (extra == 2) start = 1'b1;
            end
            if (extra == 1 && lat == 6) begin
                scramble_inputs();
                start = 1'b1;
            end
        end
        repeat (6) begin
            @(negedge clk);
            start = 1'b0;
        end

        chk("done_seen", int'(seen), 1);
        chk("done_latency", lat, 2 + exp_busy);
        chk("busy_cycles", busy_cnt, exp_busy);
        chk("done_pulses", done_cnt, 1);
        chk("cs_cycles", cs_cnt, exp_busy);
        chk("write_count", wr_idx, l);
        order_bad = 0;
        for (int i = 0; i < l && i < wr_idx; i++)
            if (int'(wr_log[i]) != (d + i) % P) order_bad++;
        chk("write_order", order_bad, 0);
        chk("protocol", proto_bad, 0);
        check_mem("memory");
        $display("op mode=%0d src=%03h dst=%03h len=%0d fill=%02h extra=%0d busy=%0d lat=%0d",
                 m, s, d, l, f, extra, busy_cnt, lat);
    endtask

    task automatic mid_reset_test();
        int lat;
        poke(16'h40, 8'h9C); poke(16'h41, 8'h3E); poke(16'h42, 8'h77); poke(16'h43, 8'h05);
        ref_mem[16'h300] = ref_mem[16'h40];
        @(posedge clk);
        #1;
        start = 1'b1; mode = 1'b0; src = 10'h040; dst = 10'h300; len = 10'd4; fill = 8'h00;
        @(posedge clk);
        #1 start = 1'b0;
        lat = 1;
        while (lat < 6) begin
            @(negedge clk);
            lat++;
        end
        // Second byte's LATCH cycle.
        chk("latch_cs_rd", int'({mem_cs, mem_rdwr, mem_addr}), int'({1'b1, 1'b1, 10'h041}));
        rst = 1'b1;
        #1;
        chk("reset_cs_now", int'({busy, mem_cs, mem_rdwr}), int'({1'b0, 1'b0, 1'b1}));
        @(negedge clk);
        rst = 1'b0;
        mon_clear();
        repeat (10) @(negedge clk);
        chk("no_resume_cs", cs_cnt, 0);
        chk("no_resume_busy", busy_cnt, 0);
        chk("mid_reset_b0", int'(ram[16'h300]), 16'h9C);
        chk("mid_reset_b1", int'(ram[16'h301]), int'(ref_mem[16'h301]));
        check_mem("mid_reset_mem");
        check_idle("mid_reset_idle");
        $display("op mid-reset copy src=040 dst=300 len=4 cs_after=%0d", cs_cnt);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; mode = 1'b0; src = '0; dst = '0; len = '0; fill = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({busy, done, mem_cs, mem_rdwr, mem_addr, mem_wr_data}),
            int'({1'b0, 1'b0, 1'b0, 1'b1, 10'd0, 8'd0}));
        @(negedge clk);
        rst = 1'b0;

        for (int a = 0; a < P; a++) poke(a, 8'($urandom));
        check_idle("idle_after_reset");

        // Directed copy
        poke(16'h10, 8'hA1); poke(16'h11, 8'hB2); poke(16'h12, 8'hC3); poke(16'h13, 8'hD4);
        run_op(1'b0, 16'h10, 16'h200, 4, 8'h00, 0);
        chk("copy_b0", int'(ram[16'h200]), 16'hA1);
        chk("copy_b3", int'(ram[16'h203]), 16'hD4);
        check_idle("idle_after_copy");

        // Directed fill across the top of memory
        run_op(1'b1, 0, 16'h3FE, 4, 8'h5A, 0);
        chk("fill_3fe", int'(ram[16'h3FE]), 16'h5A);
        chk("fill_001", int'(ram[16'h001]), 16'h5A);

        // Zero length
        run_op(1'b0, 16'h20, 16'h30, 0, 8'h00, 0);

        // Start pulses while busy and during the done cycle
        run_op(1'b0, 16'h100, 16'h180, 5, 8'h00, 1);
        run_op(1'b1, 0, 16'h1C0, 6, 8'hE7, 2);

        mid_reset_test();

        // Overlapping forward copy
        poke(0, 8'h11); poke(1, 8'h22); poke(2, 8'h33);
        run_op(1'b0, 0, 1, 2, 8'h00, 0);
        chk("overlap_1", int'(ram[1]), 16'h11);
        chk("overlap_2", int'(ram[2]), 16'h11);

        // Copy with both pointers wrapping
        run_op(1'b0, 16'h3FD, 16'h3FF, 5, 8'h00, 0);

        for (int t = 0; t < 14; t++)
            run_op(1'($urandom), int'($urandom_range(0, P - 1)), int'($urandom_range(0, P - 1)),
                   int'($urandom_range(0, 24)), 8'($urandom), int'($urandom_range(0, 2)));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
